// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU.
// Produces one quotient bit per cycle on operand magnitudes and holds the
// pipeline via stall_req until the result is ready. Quotient goes to LO and
// remainder goes to HI. Only one operation can be in flight at a time.
module div_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic                  annul,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DZERO, DONE} state_t;

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         rem, dvd, dsr;
  logic                 neg_q, neg_r;
  logic                 accept, last;
  logic [W:0]           rem_sh, trial;
  logic [W-1:0]         rem_n, dvd_n, q_fix, r_fix;

  // Two's-complement magnitude. The most negative value maps to itself,
  // which still reads correctly as an unsigned magnitude.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sg);
    return (sg & x[W-1]) ? -x : x;
  endfunction

  assign accept = (state == IDLE) & start & ~annul;
  assign last   = (cnt == CNT_WIDTH'(W - 1));

  // One restoring step. dvd shifts out dividend bits at the top and takes
  // quotient bits in at the bottom. rem_sh needs W+1 bits because a divisor
  // magnitude can be as large as 2^W-1.
  always_comb begin
    rem_sh = {rem, dvd[W-1]};
    trial  = rem_sh - {1'b0, dsr};
    rem_n  = rem_sh[W-1:0];
    dvd_n  = {dvd[W-2:0], 1'b0};
    if (!trial[W]) begin
      rem_n    = trial[W-1:0];
      dvd_n[0] = 1'b1;
    end
    q_fix = neg_q ? -dvd_n : dvd_n;
    r_fix = neg_r ? -rem_n : rem_n;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake outputs. annul drops stall_req in the same cycle.
  always_comb begin
    state_n   = state;
    stall_req = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall_req = 1'b1;
        state_n   = (divisor == '0) ? DZERO : RUN;
      end
      RUN: begin
        if (annul) state_n = IDLE;
        else begin
          stall_req = 1'b1;
          if (last) state_n = DONE;
        end
      end
      DZERO: begin
        if (annul) state_n = IDLE;
        else begin
          stall_req = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, iteration, and result load. The result registers are
  // loaded on entry to DONE so they are already valid while done is high.
  // After that they hold until the next completed operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= '0;
          rem   <= '0;
          neg_q <= signed_div & (dividend[W-1] ^ divisor[W-1]);
          neg_r <= signed_div & dividend[W-1];
          dsr   <= mag(divisor, signed_div);
          // Divide by zero returns the raw dividend, so keep it unmodified.
          dvd   <= (divisor == '0) ? dividend : mag(dividend, signed_div);
        end
        RUN: if (!annul) begin
          cnt <= cnt + 1'b1;
          rem <= rem_n;
          dvd <= dvd_n;
          if (last) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        DZERO: if (!annul) begin
          quotient  <= '1;
          remainder <= dvd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for the EX-stage integer divide resource, used by SPECIAL DIV/DIVU.
- Accepts one operand pair from EX and runs restoring division one quotient bit per cycle.
- Holds the pipeline through stall_req until the result is ready, then presents quotient (LO) and remainder (HI) to the HI/LO write path.
- Single shared divider; only one operation is in flight at a time.

Parameters:
DATA_WIDTH, 32, operand/result width (`DATA_BUS width)
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high (`RST_ENABLE)
start  in  1  EX requests a divide this cycle
signed_div  in  1  1 = DIV (signed), 0 = DIVU
annul  in  1  flush: abandon the current operation (exception/branch squash)
dividend  in  DATA_WIDTH  rs value, sampled on accepted start
divisor  in  DATA_WIDTH  rt value, sampled on accepted start
stall_req  out  1  pipeline hold request to the stall controller
busy  out  1  operation in flight (state != IDLE)
done  out  1  one-cycle pulse: result valid this cycle
quotient  out  DATA_WIDTH  result to LO, held until the next done
remainder  out  DATA_WIDTH  result to HI, held until the next done

Behaviour:
- Reset (async, rst=1) sets:
  - state IDLE
  - stall_req, busy and done = 0
  - quotient and remainder = 0
  - counter and internal registers = 0
- States and transitions:
  - IDLE: start=1 is accepted. Operands, sign flag and signs are latched.
    - divisor==0 → DZERO.
    - otherwise → RUN with counter=0.
    - annul=1 in the same cycle as start: the start is ignored and the block stays IDLE.
  - DZERO: one cycle, then → DONE. Result forced to quotient=all-ones, remainder=original dividend (unsigned or signed alike).
  - RUN: one quotient bit per cycle, working on magnitudes.
    - Shift {rem, dvd} left by 1; trial = rem − |divisor| (DATA_WIDTH+1 bits).
    - If trial is non-negative: rem=trial and the new bit=1.
    - After DATA_WIDTH iterations (counter==DATA_WIDTH−1) → DONE.
  - DONE: quotient/remainder registers are loaded, done=1 for exactly this cycle, then → IDLE.
- Signed fixup, applied when loading in DONE:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Magnitudes use two's-complement abs. −2^31 / −1 yields quotient 0x8000_0000, remainder 0 with no trap.
- Latency: start accepted in cycle T → done at T+DATA_WIDTH+1 (T+33 at default); divisor==0 → done at T+2.
- Stall handshake:
  - stall_req = (state==IDLE & start & ~annul) | state==RUN | state==DZERO. It is combinational from start so the issuing instruction holds in EX on its first cycle.
  - stall_req is 0 in the DONE cycle, so the pipeline advances while done=1 and EX captures the result.
- busy = (state != IDLE).
- start while busy: ignored, with no effect on the operation in progress.
- annul:
  - In RUN or DZERO: next state IDLE, no done pulse, quotient/remainder unchanged, stall_req drops the same cycle.
  - In DONE: the result still loads and done still pulses. The squash decision belongs downstream.
- Operands are not re-sampled after acceptance; changes on dividend/divisor during RUN have no effect.
- Async reset mid-operation returns everything to the reset values immediately.

Test Plan:
- DIVU 100/7:
  - Stimulus: start=1 at T, signed_div=0.
  - Required: stall_req=1 from T..T+32, done at T+33 only, quotient=14, remainder=2; outputs held after done until the next start.
- DIV −7/2 (0xFFFF_FFF9 / 2):
  - Required: quotient=0xFFFF_FFFD (−3), remainder=0xFFFF_FFFF (−1).
  - Also run DIV 7/−2: quotient=−3, remainder=1.
- Divide by zero, DIVU 0x1234/0:
  - Required: done at T+2, quotient=0xFFFF_FFFF, remainder=0x1234, stall_req high at T and T+1 only.
- DIV 0x8000_0000 / 0xFFFF_FFFF:
  - Required: quotient=0x8000_0000, remainder=0, done at T+33.
- Annul and busy behaviour:
  - Start 1000/3, assert annul at T+10: state IDLE at T+11, no done, prior quotient/remainder unchanged.
  - Start 9/4 at T+12: normal result 2/1 at T+45.
  - Pulse start again at T+20 with different operands: ignored, result still 2/1.
- Async reset at T+5 of a running divide:
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - After release, DIVU 0xFFFF_FFFF/1: quotient 0xFFFF_FFFF, remainder 0.
